// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encoding, default parameter values and small helpers.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WAIT_CYCLES = 4;
    localparam int DEFAULT_CNT_W       = 16;

    // A MEM-stage instruction needs the SRAM when it is a load or a store.
    function automatic logic is_mem_req(input logic r_en, input logic w_en);
        return r_en | w_en;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear. Holds at all-ones
// instead of wrapping so a long-running readout never looks small.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] value_r;

    // Count qualifying cycles, stop at the maximum, clear wins over increment.
    always_ff @(posedge clk) begin
        if (clr) begin
            value_r <= {W{1'b0}};
        end else if (inc && (value_r != MAX_VAL)) begin
            value_r <= value_r + W'(1);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges the RAW
// hazard flag, the EXE branch-taken flag and MEM-stage SRAM requests into
// per-stage freeze/flush controls, runs the SRAM wait-state FSM and keeps
// saturating stall/flush counters for debug readout.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    output logic             sram_start,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             flush_if,
    output logic             bubble_exe,
    output logic             freeze_all,
    output logic             mem_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Wait counter only needs to reach WAIT_CYCLES-1.
    localparam int                WCNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES - 1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [WCNT_W-1:0] wait_cnt_nxt_s;

    logic mem_req_s;
    logic sram_start_s;
    logic freeze_all_s;
    logic mem_done_s;
    logic freeze_if_s;
    logic freeze_id_s;
    logic flush_if_s;
    logic bubble_exe_s;
    logic stall_inc_s;
    logic flush_inc_s;

    assign mem_req_s = is_mem_req(mem_r_en, mem_w_en);

    // FSM state and wait-counter registers; reset abandons any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {WCNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Next-state logic and memory-side outputs; everything held low in reset.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        sram_start_s   = 1'b0;
        freeze_all_s   = 1'b0;
        mem_done_s     = 1'b0;
        if (rst) begin
            state_nxt_s    = ST_IDLE;
            wait_cnt_nxt_s = {WCNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_req_s) begin
                        // Launch cycle already counts as the first frozen cycle.
                        sram_start_s   = 1'b1;
                        freeze_all_s   = 1'b1;
                        state_nxt_s    = ST_MEM_WAIT;
                        wait_cnt_nxt_s = WCNT_W'(1);
                    end else begin
                        state_nxt_s    = ST_IDLE;
                        wait_cnt_nxt_s = {WCNT_W{1'b0}};
                    end
                end
                ST_MEM_WAIT: begin
                    freeze_all_s = 1'b1;
                    if (wait_cnt_r == WCNT_LAST) begin
                        state_nxt_s    = ST_MEM_DONE;
                        wait_cnt_nxt_s = {WCNT_W{1'b0}};
                    end else begin
                        state_nxt_s    = ST_MEM_WAIT;
                        wait_cnt_nxt_s = wait_cnt_r + WCNT_W'(1);
                    end
                end
                ST_MEM_DONE: begin
                    // Same instruction still sits in MEM, so its request is ignored.
                    mem_done_s     = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = {WCNT_W{1'b0}};
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = {WCNT_W{1'b0}};
                end
            endcase
        end
    end

    // Branch/hazard priority; suppressed while the whole pipeline is frozen.
    always_comb begin
        freeze_if_s  = 1'b0;
        freeze_id_s  = 1'b0;
        flush_if_s   = 1'b0;
        bubble_exe_s = 1'b0;
        if (rst || freeze_all_s) begin
            freeze_if_s  = 1'b0;
            freeze_id_s  = 1'b0;
            flush_if_s   = 1'b0;
            bubble_exe_s = 1'b0;
        end else if (branch_taken) begin
            // Hazarding instruction is squashed, so the hazard is moot.
            flush_if_s   = 1'b1;
            bubble_exe_s = 1'b1;
        end else if (hazard) begin
            freeze_if_s  = 1'b1;
            bubble_exe_s = 1'b1;
        end else begin
            freeze_if_s  = 1'b0;
            bubble_exe_s = 1'b0;
        end
    end

    assign stall_inc_s = freeze_if_s | freeze_all_s;
    assign flush_inc_s = flush_if_s;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc_s),
        .value (stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_inc_s),
        .value (flush_events)
    );

    assign sram_start = sram_start_s;
    assign freeze_all = freeze_all_s;
    assign mem_done   = mem_done_s;
    assign freeze_if  = freeze_if_s;
    assign freeze_id  = freeze_id_s;
    assign flush_if   = flush_if_s;
    assign bubble_exe = bubble_exe_s;

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline.
- Combines three inputs into one coherent set of per-stage freeze and flush controls:
  - the combinational hazard flag from hazard detection;
  - the EXE-stage branch-taken flag;
  - MEM-stage memory requests, which need a fixed multi-cycle SRAM access.
- Owns the SRAM access wait-state FSM.
- Keeps saturating stall and flush event counters for debug and performance readout.

Parameters:
WAIT_CYCLES, 4, SRAM access length in cycles (>=2), counted from sram_start.
CNT_W, 16, width of the stall_cycles and flush_events counters.

Ports:
clk  in  1  pipeline clock.
rst  in  1  synchronous reset, active-high.
hazard  in  1  RAW hazard flag from hazard detection (combinational, same cycle).
branch_taken  in  1  EXE-stage branch resolved taken.
mem_r_en  in  1  MEM-stage instruction is a load.
mem_w_en  in  1  MEM-stage instruction is a store.
sram_start  out  1  one-cycle pulse that launches an SRAM access.
freeze_if  out  1  hold PC and the IF/ID register.
freeze_id  out  1  hold the ID/EXE register contents.
flush_if  out  1  clear the IF/ID register (branch squash).
bubble_exe  out  1  load a NOP into the ID/EXE register.
freeze_all  out  1  hold every pipeline register (memory wait).
mem_done  out  1  one-cycle pulse: SRAM data valid, WB register may capture.
stall_cycles  out  CNT_W  saturating count of cycles with any freeze active.
flush_events  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset:
  - state=IDLE, wait counter=0, both event counters=0.
  - All single-bit outputs 0, and held 0 during the rst cycle regardless of inputs.
- FSM states: IDLE, MEM_WAIT, MEM_DONE.
- IDLE:
  - If mem_r_en|mem_w_en:
    - sram_start=1 and freeze_all=1 combinationally this cycle.
    - Next state MEM_WAIT, wait counter <= 1.
  - Otherwise stay in IDLE.
- MEM_WAIT:
  - freeze_all=1.
  - Counter increments each cycle.
  - When counter==WAIT_CYCLES-1: next state MEM_DONE, counter <= 0.
  - Total freeze_all cycles = WAIT_CYCLES: the sram_start cycle plus WAIT_CYCLES-1 MEM_WAIT cycles.
- MEM_DONE:
  - mem_done=1, freeze_all=0, next state IDLE.
  - mem_r_en/mem_w_en are ignored in this cycle, because the same instruction is still in MEM.
  - The pipeline advances at the end of this cycle.
- Priority when freeze_all=0, evaluated combinationally:
  - branch_taken=1: flush_if=1 and bubble_exe=1; freeze_if=0 and freeze_id=0. The hazard is ignored because the hazarding instruction is squashed.
  - else hazard=1: freeze_if=1 and bubble_exe=1; freeze_id=0.
  - else all of these are 0.
- When freeze_all=1:
  - flush_if, bubble_exe, freeze_if and freeze_id are forced 0.
  - Branch and hazard are re-evaluated once freeze_all drops. Inputs are stable because the pipeline is held.
- A memory request and a branch in the same IDLE cycle: the memory request wins. No flush is issued that cycle.
- Back-to-back memory instructions: MEM_DONE -> IDLE, then the next request is accepted in the following IDLE cycle. Minimum spacing is WAIT_CYCLES+1 cycles between sram_start pulses.
- Counters:
  - stall_cycles += 1 on any cycle with freeze_if|freeze_all.
  - flush_events += 1 on any cycle with flush_if.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Both are registered outputs, updated on the clk edge.
- rst asserted mid-access:
  - The FSM returns to IDLE next edge and no mem_done is issued.
  - Counters clear.
  - The SRAM side must tolerate an abandoned access.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, MEM_WAIT=2'd1, MEM_DONE=2'd2);
  - the default WAIT_CYCLES;
  - the default CNT_W.
- One sub-module is natural: sat_counter (width parameter, inc, clr, value), instantiated twice for the event counters.
- The FSM and the priority logic stay in the top module.

Test Plan:
- rst=1 for 2 cycles with hazard=1 and branch_taken=1 -> all outputs 0, counters 0.
- hazard=1 for 3 cycles, no mem/branch -> freeze_if=1 and bubble_exe=1 each cycle; stall_cycles=3 afterwards.
- branch_taken=1 and hazard=1 in the same cycle -> flush_if=1, bubble_exe=1, freeze_if=0; flush_events=1.
- mem_r_en=1 held, WAIT_CYCLES=4:
  - sram_start pulses once at cycle 0;
  - freeze_all=1 cycles 0-3;
  - mem_done=1 at cycle 4;
  - no second sram_start at cycle 4;
  - stall_cycles=4.
- mem_w_en=1 with branch_taken=1 in the same cycle:
  - no flush during cycles 0-3;
  - flush_if=1 at cycle 4 if branch_taken is still 1;
  - flush_events=1.
- rst pulsed at cycle 2 of a memory access -> state IDLE next cycle, mem_done never asserted, counters 0.
- CNT_W=3 with 10 consecutive hazard cycles -> stall_cycles saturates at 7.
